// File: rtl/alu_issue_ctrl.sv
// Issue stage for ALU32Bit: MIPS opcode/funct decode into ALU control plus the ID/EX register.
// Optional variable shifts and GREATER decode are enabled by defining ALU_ISSUE_VSHIFT_EN.
module alu_issue_ctrl #(
  parameter int DW = 32,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  output logic          id_ready,
  input  logic [5:0]    opcode,
  input  logic [5:0]    funct,
  input  logic [4:0]    shamt,
  input  logic [15:0]   imm,
  input  logic [DW-1:0] rs_data,
  input  logic [DW-1:0] rt_data,
  input  logic          stall,
  input  logic          flush,
  input  logic          alu_ovf,
  output logic [CW-1:0] alu_ctrl,
  output logic [DW-1:0] alu_data1,
  output logic [DW-1:0] alu_data2,
  output logic [4:0]    alu_shamt,
  output logic          ex_valid,
  output logic          illegal_op,
  output logic          ovf_trap
);

  localparam logic [CW-1:0] C_ADD = 4'b0000;
  localparam logic [CW-1:0] C_SUB = 4'b0001;
  localparam logic [CW-1:0] C_AND = 4'b0010;
  localparam logic [CW-1:0] C_OR  = 4'b0011;
  localparam logic [CW-1:0] C_SLL = 4'b0100;
  localparam logic [CW-1:0] C_SRL = 4'b0101;
  localparam logic [CW-1:0] C_SRA = 4'b0110;
`ifdef ALU_ISSUE_VSHIFT_EN
  localparam logic [CW-1:0] C_GT  = 4'b0111;
`endif
  localparam logic [CW-1:0] C_LT  = 4'b1000;

  logic          dec_legal_s;
  logic          dec_trap_s;
  logic [CW-1:0] dec_ctrl_s;
  logic [DW-1:0] dec_d1_s;
  logic [DW-1:0] dec_d2_s;
  logic [4:0]    dec_sh_s;
  logic [DW-1:0] imm_sext_s;
  logic [DW-1:0] imm_zext_s;
  logic          ex_new_r;
  logic          chk_d1_r;
  logic          trap_flag_r;

  assign id_ready   = ~stall;
  assign imm_sext_s = {{(DW-16){imm[15]}}, imm};
  assign imm_zext_s = {{(DW-16){1'b0}}, imm};

  // Instruction decode: control code, operand selection and trap classification
  always_comb begin
    dec_legal_s = 1'b1;
    dec_trap_s  = 1'b0;
    dec_ctrl_s  = C_ADD;
    dec_d1_s    = rs_data;
    dec_d2_s    = rt_data;
    dec_sh_s    = shamt;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20: begin dec_ctrl_s = C_ADD; dec_trap_s = 1'b1; end
          6'h21: dec_ctrl_s = C_ADD;
          6'h22: begin dec_ctrl_s = C_SUB; dec_trap_s = 1'b1; end
          6'h23: dec_ctrl_s = C_SUB;
          6'h24: dec_ctrl_s = C_AND;
          6'h25: dec_ctrl_s = C_OR;
          6'h00: begin dec_ctrl_s = C_SLL; dec_d1_s = rt_data; end
          6'h02: begin dec_ctrl_s = C_SRL; dec_d1_s = rt_data; end
          6'h03: begin dec_ctrl_s = C_SRA; dec_d1_s = rt_data; end
          6'h2A: dec_ctrl_s = C_LT;
`ifdef ALU_ISSUE_VSHIFT_EN
          // Variable shifts take the amount from rs instead of the shamt field
          6'h04: begin dec_ctrl_s = C_SLL; dec_d1_s = rt_data; dec_sh_s = rs_data[4:0]; end
          6'h06: begin dec_ctrl_s = C_SRL; dec_d1_s = rt_data; dec_sh_s = rs_data[4:0]; end
          6'h07: begin dec_ctrl_s = C_SRA; dec_d1_s = rt_data; dec_sh_s = rs_data[4:0]; end
          6'h3A: dec_ctrl_s = C_GT;
`endif
          default: dec_legal_s = 1'b0;
        endcase
      end
      6'h08: begin dec_ctrl_s = C_ADD; dec_d2_s = imm_sext_s; dec_sh_s = 5'd0; dec_trap_s = 1'b1; end
      6'h09: begin dec_ctrl_s = C_ADD; dec_d2_s = imm_sext_s; dec_sh_s = 5'd0; end
      6'h0C: begin dec_ctrl_s = C_AND; dec_d2_s = imm_zext_s; dec_sh_s = 5'd0; end
      6'h0D: begin dec_ctrl_s = C_OR;  dec_d2_s = imm_zext_s; dec_sh_s = 5'd0; end
      6'h0A: begin dec_ctrl_s = C_LT;  dec_d2_s = imm_sext_s; dec_sh_s = 5'd0; end
      6'h23: begin dec_ctrl_s = C_ADD; dec_d2_s = imm_sext_s; dec_sh_s = 5'd0; end
      6'h2B: begin dec_ctrl_s = C_ADD; dec_d2_s = imm_sext_s; dec_sh_s = 5'd0; end
      6'h04: begin dec_ctrl_s = C_SUB; dec_d2_s = rt_data;    dec_sh_s = 5'd0; end
      default: dec_legal_s = 1'b0;
    endcase
  end

  // ID/EX register, bubble/stall/flush handling and overflow trap pipeline
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_ctrl    <= C_ADD;
      alu_data1   <= '0;
      alu_data2   <= '0;
      alu_shamt   <= 5'd0;
      ex_valid    <= 1'b0;
      illegal_op  <= 1'b0;
      ovf_trap    <= 1'b0;
      ex_new_r    <= 1'b0;
      chk_d1_r    <= 1'b0;
      trap_flag_r <= 1'b0;
    end else if (flush) begin
      ex_valid   <= 1'b0;
      ex_new_r   <= 1'b0;
      chk_d1_r   <= 1'b0;
      ovf_trap   <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      // ex_new limits the check to the first EX cycle, so a stalled op traps once
      chk_d1_r <= ex_valid & ex_new_r & trap_flag_r;
      ovf_trap <= chk_d1_r & alu_ovf;
      if (stall) begin
        ex_new_r   <= 1'b0;
        illegal_op <= 1'b0;
      end else if (id_valid) begin
        alu_data1   <= dec_d1_s;
        alu_data2   <= dec_d2_s;
        alu_shamt   <= dec_sh_s;
        alu_ctrl    <= dec_legal_s ? dec_ctrl_s : C_ADD;
        ex_valid    <= dec_legal_s;
        ex_new_r    <= dec_legal_s;
        trap_flag_r <= dec_legal_s & dec_trap_s;
        illegal_op  <= ~dec_legal_s;
      end else begin
        ex_valid   <= 1'b0;
        ex_new_r   <= 1'b0;
        illegal_op <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl with a registered ALU overflow model.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic        id_ready;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        stall;
  logic        flush;
  logic        alu_ovf;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_data1;
  logic [31:0] alu_data2;
  logic [4:0]  alu_shamt;
  logic        ex_valid;
  logic        illegal_op;
  logic        ovf_trap;

  logic        alu_ovf_m = 1'b0;
  logic        ovf_force;
  int          checks = 0;
  int          errors = 0;
  int          pulses;

  alu_issue_ctrl #(.DW(32), .CW(4)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ready(id_ready),
    .opcode(opcode), .funct(funct), .shamt(shamt), .imm(imm),
    .rs_data(rs_data), .rt_data(rt_data), .stall(stall), .flush(flush),
    .alu_ovf(alu_ovf), .alu_ctrl(alu_ctrl), .alu_data1(alu_data1),
    .alu_data2(alu_data2), .alu_shamt(alu_shamt), .ex_valid(ex_valid),
    .illegal_op(illegal_op), .ovf_trap(ovf_trap)
  );

  always #5 clk = ~clk;

  // Signed overflow of the ALU for ADD/SUB, registered like ALU32Bit
  function automatic logic ovf_of(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    if (c == 4'b0000) begin
      r = a + b;
      return (a[31] == b[31]) && (r[31] != a[31]);
    end else if (c == 4'b0001) begin
      r = a - b;
      return (a[31] != b[31]) && (r[31] != a[31]);
    end
    return 1'b0;
  endfunction

  always @(posedge clk) alu_ovf_m <= ovf_of(alu_ctrl, alu_data1, alu_data2);
  assign alu_ovf = alu_ovf_m | ovf_force;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [15:0] im, input logic [31:0] rs, input logic [31:0] rt);
    id_valid = 1'b1; opcode = op; funct = fn; shamt = sh; imm = im; rs_data = rs; rt_data = rt;
  endtask

  task automatic idle();
    id_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, 32'(alu_ctrl), 32'd0);
    chk({tag, "_d1"}, alu_data1, 32'd0);
    chk({tag, "_d2"}, alu_data2, 32'd0);
    chk({tag, "_sh"}, 32'(alu_shamt), 32'd0);
    chk({tag, "_ev"}, 32'(ex_valid), 32'd0);
    chk({tag, "_ill"}, 32'(illegal_op), 32'd0);
    chk({tag, "_trap"}, 32'(ovf_trap), 32'd0);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; ovf_force = 1'b0;
    issue(6'h00, 6'h00, 5'd0, 16'h0000, 32'h0, 32'h0);
    idle();
    step(); step();
    chk_all_zero("rst");
    reset = 1'b0;
    #1 chk("rdy_idle", 32'(id_ready), 32'd1);

    // add overflow: trap exactly two edges after capture
    issue(6'h00, 6'h20, 5'd0, 16'h0000, 32'h7FFFFFFF, 32'h00000001);
    step();
    chk("add_ctrl", 32'(alu_ctrl), 32'd0);
    chk("add_d1", alu_data1, 32'h7FFFFFFF);
    chk("add_d2", alu_data2, 32'h00000001);
    chk("add_ev", 32'(ex_valid), 32'd1);
    idle();
    step(); chk("add_trap_n1", 32'(ovf_trap), 32'd0);
    step(); chk("add_trap_n2", 32'(ovf_trap), 32'd1);
    step(); chk("add_trap_n3", 32'(ovf_trap), 32'd0);

    // addu with same operands never traps
    issue(6'h00, 6'h21, 5'd0, 16'h0000, 32'h7FFFFFFF, 32'h00000001);
    step(); chk("addu_ev", 32'(ex_valid), 32'd1);
    idle();
    step(); chk("addu_trap_n1", 32'(ovf_trap), 32'd0);
    step(); chk("addu_trap_n2", 32'(ovf_trap), 32'd0);
    step(); chk("addu_trap_n3", 32'(ovf_trap), 32'd0);

    // back-to-back addi / ori / sra
    issue(6'h08, 6'h00, 5'd3, 16'hFFFF, 32'h00000005, 32'h0000AAAA);
    step();
    chk("addi_ctrl", 32'(alu_ctrl), 32'd0);
    chk("addi_d1", alu_data1, 32'h00000005);
    chk("addi_d2", alu_data2, 32'hFFFFFFFF);
    chk("addi_sh", 32'(alu_shamt), 32'd0);
    issue(6'h0D, 6'h00, 5'd0, 16'hFFFF, 32'h00000003, 32'h0);
    step();
    chk("ori_ctrl", 32'(alu_ctrl), 32'd3);
    chk("ori_d2", alu_data2, 32'h0000FFFF);
    chk("ori_ev", 32'(ex_valid), 32'd1);
    issue(6'h00, 6'h03, 5'd4, 16'h0000, 32'h00000123, 32'h80000000);
    step();
    chk("sra_ctrl", 32'(alu_ctrl), 32'd6);
    chk("sra_d1", alu_data1, 32'h80000000);
    chk("sra_sh", 32'(alu_shamt), 32'd4);
    chk("sra_ev", 32'(ex_valid), 32'd1);
    idle();
    step(); chk("bubble_ev", 32'(ex_valid), 32'd0);

    // add held in EX by a 3-cycle stall: one trap pulse only
    issue(6'h00, 6'h20, 5'd0, 16'h0000, 32'h7FFFFFFF, 32'h00000001);
    step(); chk("stl_acc_ev", 32'(ex_valid), 32'd1);
    issue(6'h00, 6'h24, 5'd0, 16'h0000, 32'h00000001, 32'h00000002);
    stall = 1'b1; ovf_force = 1'b1;
    #1 chk("stl_rdy", 32'(id_ready), 32'd0);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      pulses += int'(ovf_trap);
      chk("stl_ctrl", 32'(alu_ctrl), 32'd0);
      chk("stl_d1", alu_data1, 32'h7FFFFFFF);
      chk("stl_d2", alu_data2, 32'h00000001);
      chk("stl_ev", 32'(ex_valid), 32'd1);
    end
    stall = 1'b0; idle();
    for (int i = 0; i < 3; i++) begin
      step();
      pulses += int'(ovf_trap);
    end
    ovf_force = 1'b0;
    chk("stl_pulses", 32'(pulses), 32'd1);

    // flush with stall and a valid sub kills the pending trap
    issue(6'h00, 6'h22, 5'd0, 16'h0000, 32'h80000000, 32'h00000001);
    step();
    chk("fl_acc_ev", 32'(ex_valid), 32'd1);
    chk("fl_acc_ctrl", 32'(alu_ctrl), 32'd1);
    stall = 1'b1; flush = 1'b1;
    step();
    chk("fl_ev", 32'(ex_valid), 32'd0);
    chk("fl_trap0", 32'(ovf_trap), 32'd0);
    stall = 1'b0; flush = 1'b0; idle(); ovf_force = 1'b1;
    step(); chk("fl_trap1", 32'(ovf_trap), 32'd0);
    step(); chk("fl_trap2", 32'(ovf_trap), 32'd0);
    ovf_force = 1'b0;

    // undecodable opcode: one-cycle pulse, bubble, ADD forced
    issue(6'h3F, 6'h00, 5'd0, 16'h0000, 32'h1, 32'h2);
    step();
    chk("ill_pulse", 32'(illegal_op), 32'd1);
    chk("ill_ev", 32'(ex_valid), 32'd0);
    chk("ill_ctrl", 32'(alu_ctrl), 32'd0);
    idle();
    step(); chk("ill_clear", 32'(illegal_op), 32'd0);

    // funct 04 (sllv)
    issue(6'h00, 6'h04, 5'd0, 16'h0000, 32'h00000009, 32'h00000010);
    step();
`ifdef ALU_ISSUE_VSHIFT_EN
    chk("sllv_ev", 32'(ex_valid), 32'd1);
    chk("sllv_ctrl", 32'(alu_ctrl), 32'd4);
    chk("sllv_sh", 32'(alu_shamt), 32'd9);
    chk("sllv_d1", alu_data1, 32'h00000010);
    chk("sllv_ill", 32'(illegal_op), 32'd0);
`else
    chk("sllv_ill", 32'(illegal_op), 32'd1);
    chk("sllv_ev", 32'(ex_valid), 32'd0);
`endif

    // slt / beq / lw back to back
    issue(6'h00, 6'h2A, 5'd0, 16'h0000, 32'h00000003, 32'h00000004);
    step();
    chk("slt_ctrl", 32'(alu_ctrl), 32'd8);
    chk("slt_d1", alu_data1, 32'h00000003);
    chk("slt_d2", alu_data2, 32'h00000004);
    chk("slt_ill", 32'(illegal_op), 32'd0);
    issue(6'h04, 6'h00, 5'd7, 16'h1234, 32'h00000001, 32'h00000002);
    step();
    chk("beq_ctrl", 32'(alu_ctrl), 32'd1);
    chk("beq_d2", alu_data2, 32'h00000002);
    chk("beq_sh", 32'(alu_shamt), 32'd0);
    issue(6'h23, 6'h00, 5'd0, 16'h8000, 32'h00000100, 32'h0);
    step();
    chk("lw_ctrl", 32'(alu_ctrl), 32'd0);
    chk("lw_d2", alu_data2, 32'hFFFF8000);
    chk("lw_ev", 32'(ex_valid), 32'd1);

    // reset mid-stream with an overflowing add in flight
    issue(6'h00, 6'h20, 5'd0, 16'h0000, 32'h7FFFFFFF, 32'h00000001);
    step();
    idle(); reset = 1'b1; ovf_force = 1'b1;
    step(); chk("mrst_trap1", 32'(ovf_trap), 32'd0);
    step(); chk_all_zero("mrst");
    reset = 1'b0;
    step(); chk("mrst_trap3", 32'(ovf_trap), 32'd0);
    step(); chk("mrst_trap4", 32'(ovf_trap), 32'd0);
    ovf_force = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
